jt93cxx_serial: RTL and testbench
=================================

# jt93cxx_serial

Parametrised model of a 93Cxx-family Microwire serial EEPROM, serving as the non-volatile settings store behind the CPU's bit-banged I/O latches (chip select, clock and data in; data out read back through a system status port). It is the generalised replacement for the fixed 16-bit, 64-word part. Data width and depth are configurable, and it adds:

- sequential read,
- ERAL/WRAL,
- write-enable latching,
- a cycle-accurate programming busy period.

A dump port lets the frame load and save contents to the SD card.

## Interface
Parameters:
- DW, 16, data word width; legal values 8 or 16.
- AW, 6, address width; memory holds 2**AW words.
- BUSY_CYCLES, 256, clk cycles of the programming busy period; elaboration error if less than 2**AW+1.

Ports:
- clk  in  1  system clock; every input is synchronous to it.
- rst  in  1  reset, asynchronous, active-high.
- sclk  in  1  serial clock; rising edge detected on clk.
- sdi  in  1  serial data in; sampled on the sclk rising-edge detect.
- scs  in  1  chip select, active high.
- sdo  out  1  serial data out, or ready/busy status.
- busy  out  1  high while programming.
- dump_addr  in  AW  dump word address.
- dump_we  in  1  dump write strobe, one clk.
- dump_din  in  DW  dump write data.
- dump_dout  out  DW  dump read data, registered, 1-cycle latency.

## Operation
- Reset values: all states cleared to IDLE; sdo=1, busy=0, dump_dout=0; write-enable latch (WEN) cleared. Memory contents are not reset.
- Frame decode:
  - START state: while scs=1, leading zeros are ignored; the first 1 is the start bit.
  - Then 2 opcode bits, then AW address bits, MSB first.
  - WRITE and WRAL then take DW data bits, MSB first.
- Opcodes:
  - 10 READ; 01 WRITE; 11 ERASE.
  - 00 selects an extended command from the top 2 address bits: 11 EWEN, 00 EWDS, 10 ERAL, 01 WRAL.
- States: IDLE, START, OPCODE, ADDR, DATA_IN, READ_OUT, WAIT_CS, PROG.
- READ:
  - After the last address bit, sdo drives a dummy 0.
  - Each following sclk rise shifts out the next data bit, MSB first.
  - After DW bits the address increments, wrapping from 2**AW-1 to 0, and output continues (sequential read).
- EWEN sets WEN; EWDS clears it. Neither causes a busy period.
- WRITE, ERASE, ERAL, WRAL:
  - Valid only once the frame is complete and scs falls.
  - If WEN=0 the command is discarded, with no busy.
  - Otherwise go to PROG: busy=1 for BUSY_CYCLES clk cycles.
  - ERASE writes all-ones.
  - ERAL and WRAL write one word per clk during PROG, starting at address 0.
- Status output: during PROG with scs=1, sdo=0. After PROG, sdo=1 while scs stays high, until the next start bit.
- Start bits are ignored during PROG.
- scs falling mid-frame aborts the frame: no write, return to IDLE.
- Idle or deselected: sdo=1.
- rst during PROG aborts the remaining words. Words already written stay written.

## Timing
- sclk edge detect: a rise is registered one clk after sclk goes high. The sdi sample and the sdo update both occur on that clk.
- Minimum sclk high and low time: 2 clk.
- Programming commit: the first memory write occurs on the clk after scs falls. busy rises on that same clk.
- Dump write vs. serial commit in the same cycle:
  - The dump write takes priority.
  - If the addresses collide, the serial word is dropped.
  - If they differ, both writes complete.

## Configuration
- JT93CXX_DUMP_EN defined: the dump port is functional; memory is dual-port (serial side and dump side).
- JT93CXX_DUMP_EN undefined: dump_we is ignored and dump_dout stays at 0; memory is single-port. The ports remain present.

## Structure
- Package jt93cxx_pkg holds:
  - opcode constants (OP_READ, OP_WRITE, OP_ERASE, OP_EXT);
  - extended-code constants;
  - the state enumeration.
- Sub-module jt93cxx_mem: the 2**AW x DW array, with a serial port and an optional dump port, plus the write-priority logic.

## Test plan
- Dump-load 0x1234 at address 5, then serial READ of address 5 → sdo gives dummy 0 then 0001001000110100; the second word read continues at address 6.
- WRITE 0xBEEF to address 3 with WEN=0 → busy never rises; a READ of address 3 returns the old value.
- EWEN, then WRITE 0xBEEF to address 3 → on the scs fall busy=1 for exactly BUSY_CYCLES clk; sdo=0 until done, then 1; dump_dout at address 3 = 0xBEEF.
- EWEN, then WRAL 0x00A5 with AW=6, DW=8 (data 0xA5) → all 64 words = 0xA5; ERAL then sets them all to 0xFF.
- scs dropped after 4 address bits of a WRITE → no busy, memory unchanged, sdo=1.
- rst asserted 10 clk into ERAL → busy=0 and WEN=0 immediately; words 0..9 are 0xFF and words 10 and above are unchanged.

Source files
------------

// File: rtl/jt93cxx_pkg.sv
// Shared constants and types for the jt93cxx Microwire EEPROM model.
package jt93cxx_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b11;
  localparam logic [1:0] OP_EXT   = 2'b00;

  // Extended commands live in the top two address bits when the opcode is 00
  localparam logic [1:0] EXT_EWEN = 2'b11;
  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_WRAL = 2'b01;

  typedef enum logic [2:0] {
    IDLE, START, OPCODE, ADDR, DATA_IN, READ_OUT, WAIT_CS, PROG
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_WRITE, CMD_ERASE, CMD_ERAL, CMD_WRAL
  } cmd_t;

  function automatic logic is_bulk(input cmd_t c);
    return (c == CMD_ERAL) || (c == CMD_WRAL);
  endfunction

  function automatic logic is_erase(input cmd_t c);
    return (c == CMD_ERASE) || (c == CMD_ERAL);
  endfunction

endpackage

// File: rtl/jt93cxx_mem.sv
// 2**AW x DW word store with a serial-side port and, when JT93CXX_DUMP_EN is
// defined, a dump port whose writes win over a same-address serial write.
module jt93cxx_mem
  import jt93cxx_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ser_we,
  input  logic [AW-1:0] ser_waddr,
  input  logic [DW-1:0] ser_wdata,
  input  logic [AW-1:0] ser_raddr,
  output logic [DW-1:0] ser_rdata,
  input  logic          dump_we,
  input  logic [AW-1:0] dump_addr,
  input  logic [DW-1:0] dump_din,
  output logic [DW-1:0] dump_dout
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  assign ser_rdata = mem[ser_raddr];

`ifdef JT93CXX_DUMP_EN
  logic dump_hit;

  assign dump_hit = dump_we && (dump_addr == ser_waddr);

  always_ff @(posedge clk) begin
    if (ser_we && !dump_hit) mem[ser_waddr] <= ser_wdata;
    if (dump_we) mem[dump_addr] <= dump_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dump_dout <= '0;
    else     dump_dout <= mem[dump_addr];
  end
`else
  logic unused_dump;

  always_ff @(posedge clk) begin
    if (ser_we) mem[ser_waddr] <= ser_wdata;
  end

  assign dump_dout   = '0;
  assign unused_dump = ^{rst, dump_we, dump_addr, dump_din};
`endif

endmodule

// File: rtl/jt93cxx_serial.sv
// 93Cxx-family Microwire EEPROM model: frame decoder, sequential read, WEN latch,
// timed programming. Dump port is live only with JT93CXX_DUMP_EN defined.
module jt93cxx_serial
  import jt93cxx_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 6,
  parameter int BUSY_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          sdi,
  input  logic          scs,
  output logic          sdo,
  output logic          busy,
  input  logic [AW-1:0] dump_addr,
  input  logic          dump_we,
  input  logic [DW-1:0] dump_din,
  output logic [DW-1:0] dump_dout
);

  localparam int CW = $clog2(DW + AW + 1);
  localparam int PW = $clog2(BUSY_CYCLES + 1);

  if (!(DW == 8 || DW == 16)) begin : g_bad_dw
    $error("jt93cxx_serial: DW must be 8 or 16");
  end
  if (AW < 2) begin : g_bad_aw
    $error("jt93cxx_serial: AW must be at least 2");
  end
  if (BUSY_CYCLES < (2**AW) + 1) begin : g_bad_busy
    $error("jt93cxx_serial: BUSY_CYCLES must be at least 2**AW+1");
  end

  state_t        state, next_state;
  cmd_t          cmd;
  logic          sclk_d, rise;
  logic [CW-1:0] bit_cnt;
  logic [1:0]    op, ext;
  logic [AW-1:0] addr, addr_full, prog_addr;
  logic [DW-1:0] data_sr, shreg, rdata;
  logic          out_bit, wen, prog_done;
  logic [PW-1:0] prog_cnt;
  logic          last_op, last_addr, last_data, commit;
  logic          ser_we;
  logic [AW-1:0] ser_waddr;
  logic [DW-1:0] ser_wdata;

  assign rise      = sclk && !sclk_d;
  assign addr_full = {addr[AW-2:0], sdi};
  assign ext       = addr_full[AW-1:AW-2];
  assign last_op   = (bit_cnt == CW'(1));
  assign last_addr = (bit_cnt == CW'(AW - 1));
  assign last_data = (bit_cnt == CW'(DW - 1));
  // A complete programming frame takes effect on the clk that sees scs low
  assign commit    = (state == WAIT_CS) && !scs && (cmd != CMD_NONE) && wen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (scs) next_state = START;
      START:    if (!scs) next_state = IDLE;
                else if (rise && sdi) next_state = OPCODE;
      OPCODE:   if (!scs) next_state = IDLE;
                else if (rise && last_op) next_state = ADDR;
      ADDR:     if (!scs) next_state = IDLE;
                else if (rise && last_addr) begin
                  if (op == OP_READ)
                    next_state = READ_OUT;
                  else if (op == OP_WRITE || (op == OP_EXT && ext == EXT_WRAL))
                    next_state = DATA_IN;
                  else
                    next_state = WAIT_CS;
                end
      DATA_IN:  if (!scs) next_state = IDLE;
                else if (rise && last_data) next_state = WAIT_CS;
      READ_OUT: if (!scs) next_state = IDLE;
      WAIT_CS:  if (!scs) next_state = commit ? PROG : IDLE;
      PROG:     if (prog_cnt == '0) next_state = scs ? START : IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_d    <= 1'b0;
      bit_cnt   <= '0;
      op        <= '0;
      addr      <= '0;
      data_sr   <= '0;
      shreg     <= '0;
      out_bit   <= 1'b0;
      cmd       <= CMD_NONE;
      wen       <= 1'b0;
      prog_cnt  <= '0;
      prog_addr <= '0;
      prog_done <= 1'b1;
    end else begin
      sclk_d <= sclk;
      case (state)
        START: begin
          bit_cnt <= '0;
          cmd     <= CMD_NONE;
        end
        OPCODE: if (rise) begin
          op      <= {op[0], sdi};
          bit_cnt <= last_op ? '0 : bit_cnt + CW'(1);
        end
        ADDR: if (rise) begin
          addr    <= addr_full;
          bit_cnt <= last_addr ? '0 : bit_cnt + CW'(1);
          if (last_addr) begin
            out_bit <= 1'b0;
            case (op)
              OP_WRITE: cmd <= CMD_WRITE;
              OP_ERASE: cmd <= CMD_ERASE;
              OP_EXT: begin
                case (ext)
                  EXT_EWEN: wen <= 1'b1;
                  EXT_EWDS: wen <= 1'b0;
                  EXT_ERAL: cmd <= CMD_ERAL;
                  default:  cmd <= CMD_WRAL;
                endcase
              end
              default: cmd <= CMD_NONE;
            endcase
          end
        end
        DATA_IN: if (rise) begin
          data_sr <= {data_sr[DW-2:0], sdi};
          bit_cnt <= last_data ? '0 : bit_cnt + CW'(1);
        end
        // A fresh word is fetched on the first bit so sequential reads follow addr
        READ_OUT: if (rise) begin
          if (bit_cnt == '0) {out_bit, shreg} <= {rdata, 1'b0};
          else               {out_bit, shreg} <= {shreg, 1'b0};
          if (last_data) begin
            bit_cnt <= '0;
            addr    <= addr + AW'(1);
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        WAIT_CS: if (commit) begin
          prog_cnt  <= PW'(BUSY_CYCLES - 1);
          prog_addr <= AW'(1);
          prog_done <= !is_bulk(cmd);
        end
        PROG: begin
          prog_cnt <= prog_cnt - PW'(1);
          if (!prog_done) begin
            prog_addr <= prog_addr + AW'(1);
            if (&prog_addr) prog_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sdo       = 1'b1;
    busy      = 1'b0;
    ser_we    = 1'b0;
    ser_waddr = prog_addr;
    ser_wdata = is_erase(cmd) ? '1 : data_sr;
    case (state)
      READ_OUT: sdo = out_bit;
      WAIT_CS: if (commit) begin
        ser_we    = 1'b1;
        ser_waddr = is_bulk(cmd) ? '0 : addr;
      end
      PROG: begin
        busy   = 1'b1;
        sdo    = !scs;
        ser_we = !prog_done;
      end
      default: ;
    endcase
  end

  jt93cxx_mem #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .ser_we    (ser_we),
    .ser_waddr (ser_waddr),
    .ser_wdata (ser_wdata),
    .ser_raddr (addr),
    .ser_rdata (rdata),
    .dump_we   (dump_we),
    .dump_addr (dump_addr),
    .dump_din  (dump_din),
    .dump_dout (dump_dout)
  );

endmodule

// File: tb/tb_jt93cxx_serial.sv
// Directed bench for jt93cxx_serial: reads, gated writes, WRAL/ERAL, aborts,
// reset during programming and the dump port (JT93CXX_DUMP_EN aware).
module tb_jt93cxx_serial;
  import jt93cxx_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 6;
  localparam int BUSY = 80;

  logic          clk = 1'b0;
  logic          rst, sclk, sdi, scs, sdo, busy, dump_we;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_din, dump_dout;

  int            checks = 0;
  int            failures = 0;
  logic          last_sdo, rd_dummy;
  logic [DW-1:0] rd_buf [0:79];

  jt93cxx_serial #(.DW(DW), .AW(AW), .BUSY_CYCLES(BUSY)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .sdi       (sdi),
    .scs       (scs),
    .sdo       (sdo),
    .busy      (busy),
    .dump_addr (dump_addr),
    .dump_we   (dump_we),
    .dump_din  (dump_din),
    .dump_dout (dump_dout)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One serial bit: 2 clk low with data set up, 2 clk high; sdo captured while high
  task automatic sclk_bit(input logic b);
    @(negedge clk); sdi = b;
    @(negedge clk); sclk = 1'b1;
    @(negedge clk);
    @(negedge clk); last_sdo = sdo; sclk = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] o, input logic [AW-1:0] a);
    @(negedge clk); scs = 1'b1;
    @(negedge clk);
    sclk_bit(1'b1);
    sclk_bit(o[1]);
    sclk_bit(o[0]);
    for (int i = AW - 1; i >= 0; i--) sclk_bit(a[i]);
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    for (int i = DW - 1; i >= 0; i--) sclk_bit(d[i]);
  endtask

  task automatic cs_low();
    @(negedge clk); scs = 1'b0; sdi = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_prog();
    repeat (BUSY + 10) @(negedge clk);
  endtask

  task automatic ewen();
    send_cmd(OP_EXT, {EXT_EWEN, 4'b0000});
    cs_low();
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    send_cmd(OP_WRITE, a);
    send_data(d);
    cs_low();
    wait_prog();
  endtask

  task automatic read_seq(input logic [AW-1:0] a, input int n, input int zeros);
    @(negedge clk); scs = 1'b1;
    @(negedge clk);
    for (int z = 0; z < zeros; z++) sclk_bit(1'b0);
    sclk_bit(1'b1);
    sclk_bit(OP_READ[1]);
    sclk_bit(OP_READ[0]);
    for (int i = AW - 1; i >= 0; i--) sclk_bit(a[i]);
    rd_dummy = last_sdo;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < DW; b++) begin
        sclk_bit(1'b0);
        rd_buf[w] = {rd_buf[w][DW-2:0], last_sdo};
      end
    end
    cs_low();
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; sdi = 1'b0; scs = 1'b0;
    dump_we = 1'b0; dump_addr = '0; dump_din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sdo !== 1'b1) begin failures++; $display("[TB] FAIL reset_sdo: got %b expected 1", sdo); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (dump_dout !== 16'h0000) begin failures++; $display("[TB] FAIL reset_dump_dout: got %h expected 0000", dump_dout); end
  endtask

  task automatic setup_contents();
    int busy_seen;
    ewen();
    busy_seen = 0;
    repeat (10) begin @(negedge clk); if (busy) busy_seen++; end
    checks++;
    if (busy_seen != 0) begin failures++; $display("[TB] FAIL ewen_no_busy: busy cycles %0d expected 0", busy_seen); end
`ifdef JT93CXX_DUMP_EN
    @(negedge clk); dump_we = 1'b1; dump_addr = 6'd5; dump_din = 16'h1234;
    @(negedge clk); dump_we = 1'b0;
`else
    write_word(6'd5, 16'h1234);
`endif
    write_word(6'd6, 16'hC3A5);
    write_word(6'd3, 16'h0F0F);
    send_cmd(OP_EXT, {EXT_EWDS, 4'b0000});
    cs_low();
  endtask

  task automatic test_read();
    read_seq(6'd5, 2, 2);
    checks++;
    if (rd_dummy !== 1'b0) begin failures++; $display("[TB] FAIL read_dummy: got %b expected 0", rd_dummy); end
    checks++;
    if (rd_buf[0] !== 16'h1234) begin failures++; $display("[TB] FAIL read_word5: got %h expected 1234", rd_buf[0]); end
    checks++;
    if (rd_buf[1] !== 16'hC3A5) begin failures++; $display("[TB] FAIL read_seq_word6: got %h expected c3a5", rd_buf[1]); end
    @(negedge clk);
    checks++;
    if (sdo !== 1'b1) begin failures++; $display("[TB] FAIL idle_sdo: got %b expected 1", sdo); end
  endtask

  task automatic test_write_disabled();
    int busy_seen;
    send_cmd(OP_WRITE, 6'd3);
    send_data(16'hBEEF);
    cs_low();
    busy_seen = 0;
    repeat (BUSY + 10) begin @(negedge clk); if (busy) busy_seen++; end
    checks++;
    if (busy_seen != 0) begin failures++; $display("[TB] FAIL wen0_busy: busy cycles %0d expected 0", busy_seen); end
    read_seq(6'd3, 1, 0);
    checks++;
    if (rd_buf[0] !== 16'h0F0F) begin failures++; $display("[TB] FAIL wen0_data: got %h expected 0f0f", rd_buf[0]); end
  endtask

  task automatic test_write_enabled();
    int busy_err, sdo_err;
    logic exp_busy;
    ewen();
    send_cmd(OP_WRITE, 6'd3);
    send_data(16'hBEEF);
    @(negedge clk); scs = 1'b0; sdi = 1'b0;
    busy_err = 0; sdo_err = 0;
    for (int i = 0; i < BUSY + 10; i++) begin
      @(negedge clk);
      exp_busy = (i < BUSY);
      if (busy !== exp_busy) busy_err++;
      if (i > 0 && sdo !== !exp_busy) sdo_err++;
      if (i == 0) scs = 1'b1;
    end
    checks++;
    if (busy_err != 0) begin failures++; $display("[TB] FAIL busy_window: bad samples %0d expected 0", busy_err); end
    checks++;
    if (sdo_err != 0) begin failures++; $display("[TB] FAIL status_sdo: bad samples %0d expected 0", sdo_err); end
    cs_low();
    read_seq(6'd3, 1, 0);
    checks++;
    if (rd_buf[0] !== 16'hBEEF) begin failures++; $display("[TB] FAIL write_data: got %h expected beef", rd_buf[0]); end
`ifdef JT93CXX_DUMP_EN
    dump_addr = 6'd3;
    @(negedge clk); @(negedge clk);
    checks++;
    if (dump_dout !== 16'hBEEF) begin failures++; $display("[TB] FAIL dump_read: got %h expected beef", dump_dout); end
`endif
  endtask

  task automatic test_abort();
    int busy_seen, sdo_bad;
    @(negedge clk); scs = 1'b1;
    @(negedge clk);
    sclk_bit(1'b1);
    sclk_bit(OP_WRITE[1]);
    sclk_bit(OP_WRITE[0]);
    repeat (4) sclk_bit(1'b0);
    @(negedge clk); scs = 1'b0;
    busy_seen = 0; sdo_bad = 0;
    repeat (BUSY + 10) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (sdo !== 1'b1) sdo_bad++;
    end
    checks++;
    if (busy_seen != 0) begin failures++; $display("[TB] FAIL abort_busy: busy cycles %0d expected 0", busy_seen); end
    checks++;
    if (sdo_bad != 0) begin failures++; $display("[TB] FAIL abort_sdo: bad samples %0d expected 0", sdo_bad); end
    read_seq(6'd3, 1, 0);
    checks++;
    if (rd_buf[0] !== 16'hBEEF) begin failures++; $display("[TB] FAIL abort_mem: got %h expected beef", rd_buf[0]); end
  endtask

  task automatic test_wral();
    int bad;
    send_cmd(OP_EXT, {EXT_WRAL, 4'b0000});
    send_data(16'h00A5);
    cs_low();
    wait_prog();
    read_seq(6'd0, 64, 0);
    bad = 0;
    for (int w = 0; w < 64; w++) if (rd_buf[w] !== 16'h00A5) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL wral_words: bad words %0d expected 0", bad); end
  endtask

  task automatic test_reset_mid_eral();
    int bad, busy_seen;
    send_cmd(OP_EXT, {EXT_ERAL, 4'b0000});
    @(negedge clk); scs = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++;
    if (sdo !== 1'b1) begin failures++; $display("[TB] FAIL rst_sdo: got %b expected 1", sdo); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    send_cmd(OP_WRITE, 6'd20);
    send_data(16'h1111);
    cs_low();
    busy_seen = 0;
    repeat (BUSY + 10) begin @(negedge clk); if (busy) busy_seen++; end
    checks++;
    if (busy_seen != 0) begin failures++; $display("[TB] FAIL rst_wen_cleared: busy cycles %0d expected 0", busy_seen); end
    read_seq(6'd0, 12, 0);
    bad = 0;
    for (int w = 0; w < 10; w++) if (rd_buf[w] !== 16'hFFFF) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL rst_erased_words: bad words %0d expected 0", bad); end
    checks++;
    if (rd_buf[10] !== 16'h00A5) begin failures++; $display("[TB] FAIL rst_word10: got %h expected 00a5", rd_buf[10]); end
    checks++;
    if (rd_buf[11] !== 16'h00A5) begin failures++; $display("[TB] FAIL rst_word11: got %h expected 00a5", rd_buf[11]); end
    read_seq(6'd20, 1, 0);
    checks++;
    if (rd_buf[0] !== 16'h00A5) begin failures++; $display("[TB] FAIL rst_word20: got %h expected 00a5", rd_buf[0]); end
    read_seq(6'd63, 2, 0);
    checks++;
    if (rd_buf[0] !== 16'h00A5) begin failures++; $display("[TB] FAIL wrap_word63: got %h expected 00a5", rd_buf[0]); end
    checks++;
    if (rd_buf[1] !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_word0: got %h expected ffff", rd_buf[1]); end
  endtask

  task automatic test_eral();
    int bad;
    ewen();
    send_cmd(OP_EXT, {EXT_ERAL, 4'b0000});
    cs_low();
    wait_prog();
    read_seq(6'd0, 64, 0);
    bad = 0;
    for (int w = 0; w < 64; w++) if (rd_buf[w] !== 16'hFFFF) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL eral_words: bad words %0d expected 0", bad); end
  endtask

  task automatic test_dump();
`ifdef JT93CXX_DUMP_EN
    send_cmd(OP_WRITE, 6'd9);
    send_data(16'h1111);
    @(negedge clk); scs = 1'b0; dump_we = 1'b1; dump_addr = 6'd9; dump_din = 16'h5555;
    @(negedge clk); dump_we = 1'b0;
    wait_prog();
    read_seq(6'd9, 1, 0);
    checks++;
    if (rd_buf[0] !== 16'h5555) begin failures++; $display("[TB] FAIL dump_collision: got %h expected 5555", rd_buf[0]); end
    send_cmd(OP_WRITE, 6'd10);
    send_data(16'h2222);
    @(negedge clk); scs = 1'b0; dump_we = 1'b1; dump_addr = 6'd11; dump_din = 16'h6666;
    @(negedge clk); dump_we = 1'b0;
    wait_prog();
    read_seq(6'd10, 2, 0);
    checks++;
    if (rd_buf[0] !== 16'h2222) begin failures++; $display("[TB] FAIL dual_serial: got %h expected 2222", rd_buf[0]); end
    checks++;
    if (rd_buf[1] !== 16'h6666) begin failures++; $display("[TB] FAIL dual_dump: got %h expected 6666", rd_buf[1]); end
`else
    @(negedge clk); dump_we = 1'b1; dump_addr = 6'd9; dump_din = 16'h5555;
    @(negedge clk); dump_we = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (dump_dout !== 16'h0000) begin failures++; $display("[TB] FAIL dump_off_dout: got %h expected 0000", dump_dout); end
    read_seq(6'd9, 1, 0);
    checks++;
    if (rd_buf[0] !== 16'hFFFF) begin failures++; $display("[TB] FAIL dump_off_mem: got %h expected ffff", rd_buf[0]); end
`endif
  endtask

  initial begin
    $display("[TB] starting jt93cxx_serial bench");
    test_reset();
    setup_contents();
    test_read();
    test_write_disabled();
    test_write_enabled();
    test_abort();
    test_wral();
    test_reset_mid_eral();
    test_eral();
    test_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
